mem_access_stage: RTL and testbench

Pipeline MEM stage that succeeds the pure pass-through stage. GPR and HI/LO write-back fields from EX are forwarded unchanged for non-memory instructions. Loads and stores run over a req/ack data bus with arbitrary wait states, with byte lane selection, sign/zero extension and misalignment detection. The block stalls the pipeline while a transaction is outstanding, and sits between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_pkg.sv | 70 +++++++
 rtl/mem_access_stage_if.sv | 24 ++
 rtl/mem_lane_align.sv | 45 ++++
 rtl/mem_access_stage.sv | 152 +++++++++++++++
 tb/tb_mem_access_stage.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: op codes, FSM/size encodings and lane helpers.
package mem_pkg;

  localparam logic [3:0] MOP_NONE = 4'd0;
  localparam logic [3:0] MOP_LB   = 4'd1;
  localparam logic [3:0] MOP_LBU  = 4'd2;
  localparam logic [3:0] MOP_LH   = 4'd3;
  localparam logic [3:0] MOP_LHU  = 4'd4;
  localparam logic [3:0] MOP_LW   = 4'd5;
  localparam logic [3:0] MOP_SB   = 4'd6;
  localparam logic [3:0] MOP_SH   = 4'd7;
  localparam logic [3:0] MOP_SW   = 4'd8;
  localparam logic [3:0] MOP_LL   = 4'd9;
  localparam logic [3:0] MOP_SC   = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == MOP_LB) || (op == MOP_LBU) || (op == MOP_LH) ||
           (op == MOP_LHU) || (op == MOP_LW) || (op == MOP_LL);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW) || (op == MOP_SC);
  endfunction

  function automatic mem_size_e op_size(input logic [3:0] op);
    mem_size_e sz;
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: sz = SZ_BYTE;
      MOP_LH, MOP_LHU, MOP_SH: sz = SZ_HALF;
      default:                 sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Index of the least significant byte lane occupied by the access.
  function automatic logic [1:0] low_lane(input mem_size_e sz, input logic [1:0] off,
                                          input logic big);
    logic [1:0] lane;
    case (sz)
      SZ_BYTE: lane = big ? (2'd3 - off) : off;
      SZ_HALF: lane = big ? (off[1] ? 2'd0 : 2'd2) : {off[1], 1'b0};
      default: lane = 2'd0;
    endcase
    return lane;
  endfunction

  function automatic logic [3:0] lane_sel(input mem_size_e sz, input logic [1:0] off,
                                          input logic big);
    logic [3:0] sel;
    case (sz)
      SZ_BYTE: sel = 4'b0001 << low_lane(sz, off, big);
      SZ_HALF: sel = 4'b0011 << low_lane(sz, off, big);
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory (slave).
// Handshake: bus_req_o rises with address/sel/we/wdata valid and all of them stay
// constant until the cycle in which bus_ack_i is high; bus_rdata_i is valid only in that cycle.
interface mem_access_stage_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [3:0]        bus_sel_o;
  logic [31:0]       bus_wdata_o;
  logic              bus_ack_i;
  logic [31:0]       bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: lane enables, store-data replication, load extraction with
// sign/zero extension, and alignment check for the access size.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [3:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic        aligned_o,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  mem_size_e   sz;
  logic [1:0]  lane;
  logic [15:0] shifted;
  logic        sgn;

  assign sz      = op_size(op_i);
  assign lane    = low_lane(sz, off_i, BIG_ENDIAN);
  assign sel_o   = lane_sel(sz, off_i, BIG_ENDIAN);
  assign shifted = 16'(rdata_i >> {lane, 3'b000});
  assign sgn     = (op_i == MOP_LB) || (op_i == MOP_LH);

  always_comb begin
    aligned_o = 1'b1;
    wdata_o   = sdata_i;
    rdata_o   = rdata_i;
    case (sz)
      SZ_BYTE: begin
        wdata_o = {4{sdata_i[7:0]}};
        rdata_o = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        aligned_o = ~off_i[0];
        wdata_o   = {2{sdata_i[15:0]}};
        rdata_o   = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      default: aligned_o = (off_i == 2'b00);
    endcase
  end
endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: passes EX results through, runs loads/stores over a req/ack bus.
// Optional LL/SC link-bit support is enabled with `define MEM_LLSC_EN.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic              whilo_i,
  input  logic [31:0]       hi_i,
  input  logic [31:0]       lo_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_sdata_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              whilo_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o,
  output logic              stallreq_o,
  output logic              adel_o,
  output logic              ades_o,
  mem_access_stage_if.master bus,
`ifdef MEM_LLSC_EN
  input  logic              llbit_clr_i,
`endif
  output mem_state_e        dbg_state_o
);
  mem_state_e  state_q;
  logic [31:0] rdata_q;
  logic        is_ld, is_st, access, aligned, misalign, start, req;
  logic        sc_fail, llsc_nop;
  logic [3:0]  sel;
  logic [31:0] lane_wdata, rdata_ext;

  mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .op_i      (mem_op_i),
    .off_i     (mem_addr_i[1:0]),
    .sdata_i   (mem_sdata_i),
    .rdata_i   (bus.bus_rdata_i),
    .aligned_o (aligned),
    .sel_o     (sel),
    .wdata_o   (lane_wdata),
    .rdata_o   (rdata_ext)
  );

`ifdef MEM_LLSC_EN
  logic llbit_q;
  assign sc_fail  = (mem_op_i == MOP_SC) && !llbit_q;
  assign llsc_nop = 1'b0;

  // Clear has priority over the set from a completing LL.
  always_ff @(posedge clk) begin
    if (rst || llbit_clr_i) begin
      llbit_q <= 1'b0;
    end else if (state_q == ST_DONE && mem_op_i == MOP_LL) begin
      llbit_q <= 1'b1;
    end else if (state_q == ST_DONE && mem_op_i == MOP_SC) begin
      llbit_q <= 1'b0;
    end
  end
`else
  assign sc_fail  = 1'b0;
  assign llsc_nop = (mem_op_i == MOP_LL) || (mem_op_i == MOP_SC);
`endif

  assign is_ld    = op_is_load(mem_op_i);
  assign is_st    = op_is_store(mem_op_i);
  assign access   = (is_ld || is_st) && !llsc_nop;
  assign misalign = access && !aligned;
  assign start    = access && aligned && !sc_fail;
  assign req      = !rst && ((state_q == ST_IDLE && start) || state_q == ST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && bus.bus_ack_i) begin
            state_q <= ST_DONE;
            if (is_ld) rdata_q <= rdata_ext;
          end else if (start) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.bus_ack_i) begin
            state_q <= ST_DONE;
            if (is_ld) rdata_q <= rdata_ext;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o    = wd_i;
    wreg_o  = wreg_i;
    wdata_o = wdata_i;
    whilo_o = whilo_i;
    hi_o    = hi_i;
    lo_o    = lo_i;
    adel_o  = 1'b0;
    ades_o  = 1'b0;
    if (misalign && state_q == ST_IDLE) begin
      wreg_o = 1'b0;
      adel_o = is_ld;
      ades_o = is_st;
    end else if (access) begin
      wreg_o = 1'b0;
      if (state_q == ST_DONE) begin
        if (is_ld) begin
          wreg_o  = wreg_i;
          wdata_o = rdata_q;
        end else if (mem_op_i == MOP_SC) begin
          wreg_o  = wreg_i;
          wdata_o = 32'd1;
        end
      end else if (sc_fail && state_q == ST_IDLE) begin
        wreg_o  = wreg_i;
        wdata_o = '0;
      end
    end else if (llsc_nop) begin
      wreg_o = 1'b0;
    end
    if (rst) begin
      wd_o    = '0;
      wreg_o  = 1'b0;
      wdata_o = '0;
      whilo_o = 1'b0;
      hi_o    = '0;
      lo_o    = '0;
    end
  end

  assign stallreq_o      = req;
  assign bus.bus_req_o   = req;
  assign bus.bus_we_o    = req && is_st;
  assign bus.bus_addr_o  = req ? {mem_addr_i[ADDR_W-1:2], 2'b00} : '0;
  assign bus.bus_sel_o   = req ? sel : 4'b0000;
  assign bus.bus_wdata_o = req ? lane_wdata : '0;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a byte-level memory model predicts write-back
// results and bus transactions; a monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_mem_access_stage;
  import mem_pkg::*;

  localparam bit BE = 1'b1;
  localparam int RW = 106;
  localparam int BW = 69;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        whilo_i = 1'b0;
  logic [31:0] hi_i = '0;
  logic [31:0] lo_i = '0;
  logic [3:0]  mem_op_i = MOP_NONE;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_sdata_i = '0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o, adel_o, ades_o;
  mem_state_e  dbg_state;
`ifdef MEM_LLSC_EN
  logic        llbit_clr_i = 1'b0;
`endif

  mem_access_stage_if #(.ADDR_W(32)) bus_if ();

  mem_access_stage #(.ADDR_W(32), .BIG_ENDIAN(BE)) dut (
    .clk         (clk),
    .rst         (rst),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .whilo_i     (whilo_i),
    .hi_i        (hi_i),
    .lo_i        (lo_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sdata_i (mem_sdata_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .whilo_o     (whilo_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .stallreq_o  (stallreq_o),
    .adel_o      (adel_o),
    .ades_o      (ades_o),
    .bus         (bus_if),
`ifdef MEM_LLSC_EN
    .llbit_clr_i (llbit_clr_i),
`endif
    .dbg_state_o (dbg_state)
  );

  // scoreboard state
  logic [RW-1:0] exp_q[$];
  logic [BW-1:0] bus_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic ins_valid = 1'b0;
  int   wait_cfg  = 0;
  logic force_ack = 1'b0;
  logic [7:0] mem_b [logic [31:0]];
  bit   llbit_m = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack(input logic [4:0] wd, input logic wreg,
      input logic [31:0] wdata, input logic whilo, input logic [31:0] hi,
      input logic [31:0] lo, input logic adel, input logic ades, input logic req);
    return {wd, wreg, wdata, whilo, hi, lo, adel, ades, req};
  endfunction

  function automatic logic [RW-1:0] dut_pack();
    return pack(wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, adel_o, ades_o, bus_if.bus_req_o);
  endfunction

  function automatic logic [7:0] rd_b(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // Memory as seen on the 32-bit bus.
  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) begin
      if (BE) w[8*(3-i) +: 8] = rd_b(wa + 32'(i));
      else    w[8*i +: 8]     = rd_b(wa + 32'(i));
    end
    return w;
  endfunction

  // bus slave with a configurable number of wait states
  initial begin
    int cnt;
    bit busy;
    cnt = 0;
    busy = 1'b0;
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = '0;
    forever begin
      @(posedge clk);
      #2;
      bus_if.bus_ack_i   = 1'b0;
      bus_if.bus_rdata_i = $urandom;
      if (bus_if.bus_req_o) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = wait_cfg;
        end
        if (cnt == 0) begin
          bus_if.bus_ack_i   = 1'b1;
          bus_if.bus_rdata_i = rd_word(bus_if.bus_addr_o);
        end else begin
          cnt--;
        end
      end else begin
        busy = 1'b0;
      end
      if (force_ack) bus_if.bus_ack_i = 1'b1;
    end
  end

  // monitor
  initial begin
    logic [RW-1:0] e;
    logic [BW-1:0] b;
    logic [BW-1:0] ba;
    forever begin
      @(negedge clk);
      if (ins_valid && !rst && !stallreq_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL retire_underflow: got retire expected none");
        end else begin
          e = exp_q.pop_front();
          check("retire", 128'(dut_pack()), 128'(e));
        end
      end
      if (bus_if.bus_req_o && bus_if.bus_ack_i) begin
        ba = {bus_if.bus_we_o, bus_if.bus_addr_o, bus_if.bus_sel_o,
              bus_if.bus_we_o ? bus_if.bus_wdata_o : 32'h0};
        if (bus_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_underflow: got %h expected none", ba);
        end else begin
          b = bus_q.pop_front();
          check("bus_txn", 128'(ba), 128'(b));
        end
      end
    end
  end

  // driver: predict, apply, wait for retirement
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input int waits, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata);
    logic        whilo = 1'($urandom);
    logic [31:0] hi = $urandom;
    logic [31:0] lo = $urandom;
    bit ld, st, llsc_en, bus;
    int n, stalls;
    bit done;
    logic [31:0] val, bwd, exp_wdata;
    logic [3:0]  sel;
    logic        exp_wreg, exp_adel, exp_ades;
`ifdef MEM_LLSC_EN
    llsc_en = 1'b1;
`else
    llsc_en = 1'b0;
`endif
    ld = op inside {MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW, MOP_LL};
    st = op inside {MOP_SB, MOP_SH, MOP_SW, MOP_SC};
    n  = (op inside {MOP_LB, MOP_LBU, MOP_SB}) ? 1 : (op inside {MOP_LH, MOP_LHU, MOP_SH}) ? 2 : 4;
    exp_wreg = wreg; exp_wdata = wdata; exp_adel = 1'b0; exp_ades = 1'b0; bus = 1'b0;
    if (!llsc_en && (op == MOP_LL || op == MOP_SC)) begin
      exp_wreg = 1'b0;
    end else if (ld || st) begin
      if ((addr % n) != 0) begin
        exp_wreg = 1'b0; exp_adel = ld; exp_ades = st;
      end else if (op == MOP_SC && !llbit_m) begin
        exp_wdata = 32'h0;
      end else begin
        bus = 1'b1;
        sel = 4'b0000;
        for (int i = 0; i < n; i++) begin
          int bi = int'((addr + 32'(i)) % 4);
          sel[BE ? 3 - bi : bi] = 1'b1;
        end
        bwd = 32'h0;
        if (ld) begin
          val = 32'h0;
          for (int i = 0; i < n; i++) begin
            if (BE) val = (val << 8) | 32'(rd_b(addr + 32'(i)));
            else    val = val | (32'(rd_b(addr + 32'(i))) << (8 * i));
          end
          if (op == MOP_LB && val[7])  val = val | 32'hFFFF_FF00;
          if (op == MOP_LH && val[15]) val = val | 32'hFFFF_0000;
          exp_wdata = val;
          if (op == MOP_LL) llbit_m = 1'b1;
        end else begin
          bwd = (n == 1) ? {4{sdata[7:0]}} : (n == 2) ? {2{sdata[15:0]}} : sdata;
          for (int i = 0; i < n; i++)
            mem_b[addr + 32'(i)] = sdata[8*(BE ? n - 1 - i : i) +: 8];
          exp_wreg = (op == MOP_SC) ? wreg : 1'b0;
          if (op == MOP_SC) begin
            exp_wdata = 32'd1;
            llbit_m   = 1'b0;
          end
        end
        bus_q.push_back({st, addr & 32'hFFFF_FFFC, sel, bwd});
      end
    end
    exp_q.push_back(pack(wd, exp_wreg, exp_wdata, whilo, hi, lo, exp_adel, exp_ades, 1'b0));

    wd_i = wd; wreg_i = wreg; wdata_i = wdata; whilo_i = whilo; hi_i = hi; lo_i = lo;
    mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata;
    wait_cfg = waits;
    ins_valid = 1'b1;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!stallreq_o) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL retire_timeout: got no retire in 64 cycles expected retire");
    end
    check("stall_cycles", 128'(stalls), 128'(bus ? waits + 1 : 0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a would-be memory op on the inputs
    rst = 1'b1;
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF; whilo_i = 1'b1;
    hi_i = 32'h1111_2222; lo_i = 32'h3333_4444;
    mem_op_i = MOP_LW; mem_addr_i = 32'h1000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 128'({dut_pack(), bus_if.bus_we_o, bus_if.bus_addr_o,
                                 bus_if.bus_sel_o, bus_if.bus_wdata_o}), 128'(0));
    check("reset_stall", 128'(stallreq_o), 128'(0));
    check("reset_state", 128'(dbg_state), 128'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_op_i = MOP_NONE;

    issue(MOP_NONE, 32'h0, 32'h0, 0, 5'd3, 1'b1, 32'h1234_5678);

    mem_b[32'h1000] = 8'h11; mem_b[32'h1001] = 8'hF2;
    mem_b[32'h1002] = 8'h33; mem_b[32'h1003] = 8'h44;
    issue(MOP_LB, 32'h1001, $urandom, 0, 5'd4, 1'b1, $urandom);
    issue(MOP_SH, 32'h2002, 32'h0000_BEEF, 3, 5'd5, 1'b1, $urandom);
    issue(MOP_LH, 32'h2002, $urandom, 1, 5'd6, 1'b1, $urandom);
    issue(MOP_LW, 32'h3001, $urandom, 0, 5'd7, 1'b1, $urandom);
    issue(MOP_SW, 32'h3002, $urandom, 0, 5'd8, 1'b1, $urandom);

    // reset while a load is waiting
    ins_valid = 1'b0;
    wait_cfg = 20;
    mem_op_i = MOP_LW; mem_addr_i = 32'h1020; wreg_i = 1'b1;
    @(negedge clk);
    check("rstw_req", 128'({bus_if.bus_req_o, stallreq_o}), 128'(2'b11));
    @(negedge clk);
    check("rstw_in_wait", 128'(dbg_state), 128'(ST_WAIT));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstw_state", 128'(dbg_state), 128'(ST_IDLE));
    check("rstw_outputs", 128'({dut_pack(), bus_if.bus_we_o, bus_if.bus_addr_o,
                                bus_if.bus_sel_o, bus_if.bus_wdata_o}), 128'(0));
    mem_op_i = MOP_NONE; wd_i = 5'd9; wdata_i = $urandom; wreg_i = 1'b1;
    rst = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    check("late_ack_pass", 128'(dut_pack()),
          128'(pack(wd_i, wreg_i, wdata_i, whilo_i, hi_i, lo_i, 1'b0, 1'b0, 1'b0)));
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    check("late_ack_state", 128'(dbg_state), 128'(ST_IDLE));

`ifdef MEM_LLSC_EN
    issue(MOP_LL, 32'h1010, $urandom, 1, 5'd10, 1'b1, $urandom);
    issue(MOP_SC, 32'h1014, $urandom, 0, 5'd11, 1'b1, $urandom);
    issue(MOP_LL, 32'h1010, $urandom, 0, 5'd12, 1'b1, $urandom);
    llbit_clr_i = 1'b1;
    issue(MOP_NONE, 32'h0, 32'h0, 0, 5'd13, 1'b0, $urandom);
    llbit_clr_i = 1'b0;
    llbit_m = 1'b0;
    issue(MOP_SC, 32'h1018, $urandom, 0, 5'd14, 1'b1, $urandom);
`endif

    for (int k = 0; k < 60; k++)
      issue(4'($urandom_range(0, 12)), 32'h1000 + 32'($urandom_range(0, 63)), $urandom,
            $urandom_range(0, 3), 5'($urandom), 1'($urandom), $urandom);

    ins_valid = 1'b0;
    mem_op_i = MOP_NONE;
    repeat (3) @(posedge clk);
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    check("bus_q_drained", 128'(bus_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
